// File: rtl/aes_last_round_out.sv
// Final AddRoundKey stage of the AES round pipeline.
// Results are queued in a small FIFO that the host drains over valid/ready.
module aes_last_round_out #(
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [129:0]               pkt_in,
  input  logic [127:0]               in_key,
  input  logic                       set_key,
  input  logic                       set_inv_key,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [127:0]               out_data,
  output logic                       out_en_de,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  logic [127:0]  key_enc;
  logic [127:0]  key_dec;

  logic          st_valid;
  logic [127:0]  st_data;
  logic          st_en_de;

  logic [127:0]  mem_data [DEPTH];
  logic          mem_en_de [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          wr;
  logic          rd;
  logic          full;
  logic          do_wr;
  logic          drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_enc <= '0;
      key_dec <= '0;
    end else begin
      if (set_key)     key_enc <= in_key;
      if (set_inv_key) key_dec <= in_key;
    end
  end

  // Keys come from the registers, so a same-cycle load only affects later packets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= 1'b0;
      st_data  <= '0;
      st_en_de <= 1'b0;
    end else if (pkt_in[129]) begin
      st_valid <= 1'b1;
      st_data  <= pkt_in[128:1] ^ (pkt_in[0] ? key_dec : key_enc);
      st_en_de <= pkt_in[0];
    end else begin
      st_valid <= 1'b0;
      st_data  <= '0;
      st_en_de <= 1'b0;
    end
  end

  assign full      = (fifo_count == DEPTH_C);
  assign out_valid = (fifo_count != '0);
  assign wr        = st_valid;
  assign rd        = out_valid && out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_wr     = wr && (!full || rd);
  assign drop      = wr && full && !rd;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_data[wr_ptr]  <= st_data;
      mem_en_de[wr_ptr] <= st_en_de;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd)    rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !rd)      fifo_count <= fifo_count + CW'(1);
      else if (rd && !do_wr) fifo_count <= fifo_count - CW'(1);
    end
  end

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  assign almost_full = (fifo_count >= AFULL_C);
  assign out_data    = out_valid ? mem_data[rd_ptr] : '0;
  assign out_en_de   = out_valid ? mem_en_de[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_aes_last_round_out.sv
// Directed bench for aes_last_round_out: key select, latency, back-pressure,
// overflow, full read/write and asynchronous reset.
module tb_aes_last_round_out;

  logic         clk;
  logic         rst_n;
  logic [129:0] pkt_in;
  logic [127:0] in_key;
  logic         set_key;
  logic         set_inv_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_en_de;
  logic [2:0]   fifo_count;
  logic         almost_full;
  logic         overflow;
  logic         clr_ovf;

  int tests_run;
  int tests_failed;

  aes_last_round_out #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .pkt_in(pkt_in), .in_key(in_key),
    .set_key(set_key), .set_inv_key(set_inv_key), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_en_de(out_en_de),
    .fifo_count(fifo_count), .almost_full(almost_full), .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic load_enc(input logic [127:0] k);
    in_key = k; set_key = 1'b1;
    cycle();
    set_key = 1'b0;
  endtask

  task automatic load_dec(input logic [127:0] k);
    in_key = k; set_inv_key = 1'b1;
    cycle();
    set_inv_key = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (out_data !== 128'h0) begin tests_failed++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
    tests_run++;
    if (fifo_count !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
    tests_run++;
    if ({almost_full, overflow, out_en_de} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_flags: got %b expected 000", {almost_full, overflow, out_en_de}); end
  endtask

  task automatic test_encrypt();
    load_enc({16{8'h0f}});
    pkt_in = {1'b1, {16{8'hf0}}, 1'b0};
    cycle();
    pkt_in = '0;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL enc_latency_early: got %b expected 0", out_valid); end
    cycle();
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL enc_valid: got %b expected 1", out_valid); end
    tests_run++;
    if (out_data !== {16{8'hff}}) begin tests_failed++; $display("[TB] FAIL enc_data: got %h expected %h", out_data, {16{8'hff}}); end
    tests_run++;
    if (out_en_de !== 1'b0) begin tests_failed++; $display("[TB] FAIL enc_en_de: got %b expected 0", out_en_de); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 128'h0) begin tests_failed++; $display("[TB] FAIL enc_drain: got valid %b data %h expected 0/0", out_valid, out_data); end
  endtask

  task automatic test_decrypt();
    load_enc({16{8'h11}});
    load_dec({16{8'h22}});
    pkt_in = {1'b1, 128'h0, 1'b1};
    cycle();
    pkt_in = '0;
    cycle();
    tests_run++;
    if (out_data !== {16{8'h22}}) begin tests_failed++; $display("[TB] FAIL dec_data: got %h expected %h", out_data, {16{8'h22}}); end
    tests_run++;
    if (out_en_de !== 1'b1) begin tests_failed++; $display("[TB] FAIL dec_en_de: got %b expected 1", out_en_de); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_same_cycle_key();
    load_enc({16{8'h55}});
    in_key = {16{8'haa}}; set_key = 1'b1;
    pkt_in = {1'b1, 128'h0, 1'b0};
    cycle();
    set_key = 1'b0;
    pkt_in = {1'b1, 128'h0, 1'b0};
    cycle();
    pkt_in = '0;
    tests_run++;
    if (out_data !== {16{8'h55}}) begin tests_failed++; $display("[TB] FAIL samekey_old: got %h expected %h", out_data, {16{8'h55}}); end
    cycle();
    tests_run++;
    if (fifo_count !== 3'd2) begin tests_failed++; $display("[TB] FAIL samekey_count: got %0d expected 2", fifo_count); end
    out_ready = 1'b1;
    cycle();
    tests_run++;
    if (out_data !== {16{8'haa}}) begin tests_failed++; $display("[TB] FAIL samekey_new: got %h expected %h", out_data, {16{8'haa}}); end
    cycle();
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL samekey_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_overflow();
    load_enc(128'h0);
    for (int i = 1; i <= 5; i++) begin
      pkt_in = {1'b1, 128'(i), 1'b0};
      cycle();
      tests_run++;
      if (fifo_count !== 3'(i - 1)) begin tests_failed++; $display("[TB] FAIL ovf_count_%0d: got %0d expected %0d", i, fifo_count, i - 1); end
      tests_run++;
      if (almost_full !== ((i - 1) >= 3)) begin tests_failed++; $display("[TB] FAIL ovf_afull_%0d: got %b expected %b", i, almost_full, (i - 1) >= 3); end
      tests_run++;
      if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_early_%0d: got %b expected 0", i, overflow); end
    end
    pkt_in = '0;
    cycle();
    tests_run++;
    if (overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow); end
    tests_run++;
    if (fifo_count !== 3'd4) begin tests_failed++; $display("[TB] FAIL ovf_count_full: got %0d expected 4", fifo_count); end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 128'(k)) begin tests_failed++; $display("[TB] FAIL ovf_drain_%0d: got valid %b data %h expected 1/%h", k, out_valid, out_data, 128'(k)); end
      cycle();
    end
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin tests_failed++; $display("[TB] FAIL ovf_empty: got valid %b count %0d expected 0/0", out_valid, fifo_count); end
    tests_run++;
    if (overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 5; i++) begin
      pkt_in = {1'b1, 128'(10 + i), 1'b0};
      cycle();
    end
    pkt_in = '0;
    out_ready = 1'b1;
    tests_run++;
    if (fifo_count !== 3'd4 || out_data !== 128'd10) begin tests_failed++; $display("[TB] FAIL fullrw_pre: got count %0d data %h expected 4/%h", fifo_count, out_data, 128'd10); end
    cycle();
    tests_run++;
    if (fifo_count !== 3'd4) begin tests_failed++; $display("[TB] FAIL fullrw_count: got %0d expected 4", fifo_count); end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL fullrw_no_drop: got %b expected 0", overflow); end
    for (int k = 11; k <= 14; k++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 128'(k)) begin tests_failed++; $display("[TB] FAIL fullrw_order_%0d: got valid %b data %h expected 1/%h", k, out_valid, out_data, 128'(k)); end
      cycle();
    end
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL fullrw_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    load_enc({16{8'h33}});
    for (int i = 0; i < 3; i++) begin
      pkt_in = {1'b1, 128'(i + 1), 1'b0};
      cycle();
    end
    pkt_in = '0;
    cycle();
    tests_run++;
    if (fifo_count !== 3'd3 || almost_full !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_pre: got count %0d afull %b expected 3/1", fifo_count, almost_full); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, out_en_de, almost_full, overflow} !== 4'b0000 || out_data !== 128'h0 || fifo_count !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_async: got valid %b data %h count %0d afull %b expected all 0", out_valid, out_data, fifo_count, almost_full);
    end
    cycle();
    cycle();
    rst_n = 1'b1;
    pkt_in = {1'b1, 128'h1234, 1'b0};
    cycle();
    pkt_in = '0;
    cycle();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 128'h1234) begin tests_failed++; $display("[TB] FAIL rstmid_keys_cleared: got valid %b data %h expected 1/%h", out_valid, out_data, 128'h1234); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    pkt_in = '0;
    in_key = '0;
    set_key = 1'b0;
    set_inv_key = 1'b0;
    out_ready = 1'b0;
    clr_ovf = 1'b0;
    cycle();
    cycle();
    test_reset();
    rst_n = 1'b1;
    cycle();
    test_encrypt();
    test_decrypt();
    test_same_cycle_key();
    test_overflow();
    test_full_rw();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
